// File: rtl/multi_clk_div_pkg.sv
// Shared constants, per-channel configuration record and the half-period helper for multi_clk_div.
// Optional lock gating is enabled with the MULTI_CLK_DIV_LOCK_GATE_EN macro (see clk_div_chan).
package multi_clk_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    // Divide ratios are carried zero-extended to MAX_W so the record and helper are width-agnostic.
    // W must stay below MAX_W so that div+1 cannot overflow.
    localparam int unsigned MAX_W = 64;

    typedef struct packed {
        logic [MAX_W-1:0] div;
        logic             en;
    } chan_cfg_t;

    function automatic logic [MAX_W-1:0] half_up(input logic [MAX_W-1:0] div);
        return (div + MAX_W'(1)) >> 1;
    endfunction

endpackage

// File: rtl/multi_clk_div_chan.sv
// One divider channel: counter, single pending-config slot, registered tick and square wave.
// With MULTI_CLK_DIV_LOCK_GATE_EN defined, a 'locked' input holds the channel idle until it rises.
module clk_div_chan
    import multi_clk_div_pkg::*;
#(
    parameter int unsigned     W         = 32,
    parameter longint unsigned RESET_DIV = 50_000_000,
    parameter logic            EN_RESET  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
`ifdef MULTI_CLK_DIV_LOCK_GATE_EN
    input  logic         locked,
`endif
    input  logic         acc_i,
    input  logic [W-1:0] acc_div_i,
    input  logic         acc_en_i,
    output logic         pend_valid_o,
    output logic         tick_o,
    output logic         sq_o
);

    logic [W-1:0]     cnt_q, cnt_d;
    logic [MAX_W-1:0] div_q, div_d;
    logic             en_q, en_d;
    logic             started_q, started_d;
    logic             pend_valid_q, pend_valid_d;
    chan_cfg_t        pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    logic             run;
    logic             wrap;
    logic [W-1:0]     cntInc;

`ifdef MULTI_CLK_DIV_LOCK_GATE_EN
    assign run = locked;
`else
    assign run = 1'b1;
`endif

    assign cntInc = cnt_q + W'(1);
    assign wrap   = (MAX_W'(cnt_q) == (div_q - MAX_W'(1)));

    // started_q keeps sq low until the first full period after reset, enable or lock.
    always_comb begin
        cnt_d        = cnt_q;
        div_d        = div_q;
        en_d         = en_q;
        started_d    = started_q;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        tick_d       = 1'b0;
        sq_d         = sq_q;

        if (acc_i) begin
            pend_d.div   = MAX_W'(acc_div_i);
            pend_d.en    = acc_en_i;
            pend_valid_d = 1'b1;
        end

        if (!run) begin
            cnt_d     = '0;
            sq_d      = 1'b0;
            started_d = 1'b0;
        end else if (!en_q) begin
            cnt_d     = '0;
            sq_d      = 1'b0;
            started_d = 1'b0;
            if (pend_valid_q) begin
                div_d        = pend_q.div;
                en_d         = pend_q.en;
                pend_valid_d = 1'b0;
                if (pend_q.en) begin
                    tick_d    = 1'b1;
                    sq_d      = 1'b1;
                    started_d = 1'b1;
                end
            end
        end else if (wrap) begin
            cnt_d     = '0;
            tick_d    = 1'b1;
            sq_d      = 1'b1;
            started_d = 1'b1;
            if (pend_valid_q) begin
                div_d        = pend_q.div;
                en_d         = pend_q.en;
                pend_valid_d = 1'b0;
                if (!pend_q.en) begin
                    tick_d    = 1'b0;
                    sq_d      = 1'b0;
                    started_d = 1'b0;
                end
            end
        end else begin
            cnt_d = cntInc;
            sq_d  = started_q && (MAX_W'(cntInc) < half_up(div_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            div_q        <= MAX_W'(RESET_DIV);
            en_q         <= EN_RESET;
            started_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            tick_q       <= 1'b0;
            sq_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            en_q         <= en_d;
            started_q    <= started_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            tick_q       <= tick_d;
            sq_q         <= sq_d;
        end
    end

    assign pend_valid_o = pend_valid_q;
    assign tick_o       = tick_q;
    assign sq_o         = sq_q;

endmodule

// File: rtl/multi_clk_div.sv
// NCH-channel clock-enable generator: config decode, ready mux and error pulse around clk_div_chan.
// Define MULTI_CLK_DIV_LOCK_GATE_EN to add the 'locked' input that gates every channel.
module multi_clk_div
    import multi_clk_div_pkg::*;
#(
    parameter int unsigned     NCH       = 3,
    parameter int unsigned     W         = 32,
    parameter longint unsigned RESET_DIV = 50_000_000,
    parameter logic [NCH-1:0]  EN_INIT   = '1,
    localparam int unsigned    CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
`ifdef MULTI_CLK_DIV_LOCK_GATE_EN
    input  logic           locked,
`endif
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [W-1:0]   cfg_div,
    input  logic           cfg_en,
    output logic           cfg_err,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq
);

    logic [NCH-1:0]      pendValid;
    logic [NCH-1:0]      chAcc;
    logic [(2**CHW)-1:0] pendPad;
    logic                chValid;
    logic                divOk;
    logic                accept;
    logic                err_q, err_d;

    // Channel numbers beyond NCH read as ready so such requests complete and are flagged as errors.
    always_comb begin
        pendPad = '0;
        for (int i = 0; i < NCH; i++) begin
            pendPad[i] = pendValid[i];
        end
    end

    assign chValid   = (32'(cfg_ch) < NCH);
    assign divOk     = (cfg_div >= W'(MIN_DIV));
    assign cfg_ready = !pendPad[cfg_ch];
    assign accept    = cfg_valid && cfg_ready;

    always_comb begin
        err_d = accept && (!divOk || !chValid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cfg_err = err_q;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign chAcc[i] = accept && divOk && (cfg_ch == CHW'(i));

        clk_div_chan #(
            .W         (W),
            .RESET_DIV (RESET_DIV),
            .EN_RESET  (EN_INIT[i])
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
`ifdef MULTI_CLK_DIV_LOCK_GATE_EN
            .locked       (locked),
`endif
            .acc_i        (chAcc[i]),
            .acc_div_i    (cfg_div),
            .acc_en_i     (cfg_en),
            .pend_valid_o (pendValid[i]),
            .tick_o       (tick[i]),
            .sq_o         (sq[i])
        );
    end

endmodule

// File: tb/tb_multi_clk_div.sv
// Directed testbench for multi_clk_div with NCH=3, W=8, RESET_DIV=10.
// The lock-gate scenario is built only when MULTI_CLK_DIV_LOCK_GATE_EN is defined.
module tb_multi_clk_div;

    logic       clk;
    logic       rst;
`ifdef MULTI_CLK_DIV_LOCK_GATE_EN
    logic       locked;
`endif
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_en;
    logic       cfg_err;
    logic [2:0] tick;
    logic [2:0] sq;

    int checks;
    int failures;

    multi_clk_div #(
        .NCH       (3),
        .W         (8),
        .RESET_DIV (10),
        .EN_INIT   (3'b111)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MULTI_CLK_DIV_LOCK_GATE_EN
        .locked    (locked),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .sq        (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference for an untouched div=10 channel, k edges after reset release.
    function automatic logic freeTick(input int k);
        return (k > 0) && (k % 10 == 0);
    endfunction

    function automatic logic freeSq(input int k);
        return (k >= 10) && (k % 10 < 5);
    endfunction

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cfg_ch = 2'd0;
        doReset();
        checks++;
        if (tick !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_tick: got %b expected %b", tick, 3'b000);
        end
        checks++;
        if (sq !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_sq: got %b expected %b", sq, 3'b000);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b expected 1", cfg_ready);
        end
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_err: got %b expected 0", cfg_err);
        end
    endtask

    task automatic test_free_run();
        logic [2:0] expTick, expSq;
        doReset();
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            expTick = {3{freeTick(k)}};
            expSq   = {3{freeSq(k)}};
            checks++;
            if (tick !== expTick) begin
                failures++;
                $display("[TB] FAIL free_tick k=%0d: got %b expected %b", k, tick, expTick);
            end
            checks++;
            if (sq !== expSq) begin
                failures++;
                $display("[TB] FAIL free_sq k=%0d: got %b expected %b", k, sq, expSq);
            end
        end
    endtask

    task automatic test_ratio_change();
        logic [2:0] expTick, expSq;
        logic       expReady;
        doReset();
        cfg_ch = 2'd1;
        for (int k = 1; k <= 3; k++) @(negedge clk);
        cfg_valid = 1'b1;
        cfg_div   = 8'd4;
        cfg_en    = 1'b1;
        for (int k = 4; k <= 24; k++) begin
            @(negedge clk);
            expTick    = {3{freeTick(k)}};
            expSq      = {3{freeSq(k)}};
            expTick[1] = (k >= 10) && ((k - 10) % 4 == 0);
            expSq[1]   = (k >= 10) && ((k - 10) % 4 < 2);
            expReady   = (k >= 10);
            checks++;
            if (tick !== expTick) begin
                failures++;
                $display("[TB] FAIL ratio_tick k=%0d: got %b expected %b", k, tick, expTick);
            end
            checks++;
            if (sq !== expSq) begin
                failures++;
                $display("[TB] FAIL ratio_sq k=%0d: got %b expected %b", k, sq, expSq);
            end
            checks++;
            if (cfg_ready !== expReady) begin
                failures++;
                $display("[TB] FAIL ratio_ready k=%0d: got %b expected %b", k, cfg_ready, expReady);
            end
            if (k == 4) cfg_valid = 1'b0;
        end
    endtask

    task automatic test_odd_div();
        logic [2:0] expTick, expSq;
        doReset();
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 8'd5;
        cfg_en    = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            expTick    = {3{freeTick(k)}};
            expSq      = {3{freeSq(k)}};
            expTick[0] = (k >= 10) && ((k - 10) % 5 == 0);
            expSq[0]   = (k >= 10) && ((k - 10) % 5 < 3);
            checks++;
            if (tick !== expTick) begin
                failures++;
                $display("[TB] FAIL odd_tick k=%0d: got %b expected %b", k, tick, expTick);
            end
            checks++;
            if (sq !== expSq) begin
                failures++;
                $display("[TB] FAIL odd_sq k=%0d: got %b expected %b", k, sq, expSq);
            end
            if (k == 1) cfg_valid = 1'b0;
        end
    endtask

    task automatic test_bad_div();
        logic [2:0] expTick;
        logic       expErr;
        doReset();
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_div   = 8'd1;
        cfg_en    = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            expErr  = (k == 1) || (k == 2);
            expTick = {3{freeTick(k)}};
            checks++;
            if (cfg_err !== expErr) begin
                failures++;
                $display("[TB] FAIL bad_err k=%0d: got %b expected %b", k, cfg_err, expErr);
            end
            checks++;
            if (cfg_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL bad_ready k=%0d: got %b expected 1", k, cfg_ready);
            end
            checks++;
            if (tick !== expTick) begin
                failures++;
                $display("[TB] FAIL bad_tick k=%0d: got %b expected %b", k, tick, expTick);
            end
            if (k == 1) cfg_div = 8'd0;
            if (k == 2) cfg_valid = 1'b0;
        end
    endtask

    task automatic test_disable_enable();
        logic [2:0] expTick, expSq;
        doReset();
        cfg_ch  = 2'd2;
        cfg_div = 8'd10;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            expTick    = {3{freeTick(k)}};
            expSq      = {3{freeSq(k)}};
            expTick[2] = (k == 15) || (k == 25) || (k == 35);
            expSq[2]   = (k >= 15) && ((k - 15) % 10 < 5);
            checks++;
            if (tick !== expTick) begin
                failures++;
                $display("[TB] FAIL dis_tick k=%0d: got %b expected %b", k, tick, expTick);
            end
            checks++;
            if (sq !== expSq) begin
                failures++;
                $display("[TB] FAIL dis_sq k=%0d: got %b expected %b", k, sq, expSq);
            end
            if (k == 6) begin
                cfg_valid = 1'b1;
                cfg_en    = 1'b0;
            end
            if (k == 13) begin
                cfg_valid = 1'b1;
                cfg_en    = 1'b1;
            end
            if (k == 7 || k == 14) cfg_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] expTick, expSq;
        logic       expReady;
        doReset();
        cfg_ch = 2'd1;
        cfg_en = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            expTick    = {3{freeTick(k)}};
            expSq      = {3{freeSq(k)}};
            expTick[1] = (k == 10) || (k == 16) || (k == 24);
            if (k < 10)      expSq[1] = 1'b0;
            else if (k < 16) expSq[1] = (k - 10) < 3;
            else if (k < 24) expSq[1] = (k - 16) < 4;
            else             expSq[1] = (k - 24) < 4;
            expReady = (k <= 2) || (k == 10) || (k >= 16);
            checks++;
            if (tick !== expTick) begin
                failures++;
                $display("[TB] FAIL b2b_tick k=%0d: got %b expected %b", k, tick, expTick);
            end
            checks++;
            if (sq !== expSq) begin
                failures++;
                $display("[TB] FAIL b2b_sq k=%0d: got %b expected %b", k, sq, expSq);
            end
            checks++;
            if (cfg_ready !== expReady) begin
                failures++;
                $display("[TB] FAIL b2b_ready k=%0d: got %b expected %b", k, cfg_ready, expReady);
            end
            if (k == 2) begin
                cfg_valid = 1'b1;
                cfg_div   = 8'd6;
            end
            if (k == 3) cfg_div = 8'd8;
            if (k == 11) cfg_valid = 1'b0;
        end
        // Leave a request pending, then reset mid-period.
        cfg_valid = 1'b1;
        cfg_div   = 8'd3;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_pend_ready: got %b expected 0", cfg_ready);
        end
        rst       = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (tick !== 3'b000 || sq !== 3'b000) begin
            failures++;
            $display("[TB] FAIL midrst_out: got tick=%b sq=%b expected tick=000 sq=000", tick, sq);
        end
        checks++;
        if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_cfg: got ready=%b err=%b expected ready=1 err=0", cfg_ready, cfg_err);
        end
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            expTick = {3{freeTick(j)}};
            checks++;
            if (tick !== expTick) begin
                failures++;
                $display("[TB] FAIL midrst_tick j=%0d: got %b expected %b", j, tick, expTick);
            end
        end
    endtask

`ifdef MULTI_CLK_DIV_LOCK_GATE_EN
    task automatic test_lock();
        logic [2:0] expTick;
        locked = 1'b0;
        doReset();
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            expTick = (k == 35) ? 3'b111 : 3'b000;
            checks++;
            if (tick !== expTick) begin
                failures++;
                $display("[TB] FAIL lock_tick k=%0d: got %b expected %b", k, tick, expTick);
            end
            if (k <= 25) begin
                checks++;
                if (sq !== 3'b000) begin
                    failures++;
                    $display("[TB] FAIL lock_sq k=%0d: got %b expected 000", k, sq);
                end
            end
            if (k == 25) locked = 1'b1;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_div   = 8'd10;
        cfg_en    = 1'b1;
`ifdef MULTI_CLK_DIV_LOCK_GATE_EN
        locked    = 1'b1;
`endif
        test_reset();
        test_free_run();
        test_ratio_change();
        test_odd_div();
        test_bad_div();
        test_disable_enable();
        test_back_to_back();
`ifdef MULTI_CLK_DIV_LOCK_GATE_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_clk_div.md
Name: multi_clk_div

Overview:
- Parametrised N-channel clock-enable generator; successor to the fixed single-ratio counter dividers.
- One system clock feeds NCH independent dividers, each programmable at runtime.
- Each channel produces a one-cycle tick pulse and a near-50% square wave.
- Ratio changes apply glitch-free at the period boundary. Drives 1 Hz/kHz timebases, LED blinkers and sample strobes.

Parameters:
- NCH, 3, number of channels (1..16).
- W, 32, divider/counter width.
- RESET_DIV, 50_000_000, divide ratio loaded into every channel at reset (must be >= 2 and < 2^W).
- EN_INIT, all-ones NCH bits, per-channel enable after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  request accepted when cfg_valid && cfg_ready.
- cfg_ch  in  max(1,$clog2(NCH))  target channel.
- cfg_div  in  W  new divide ratio.
- cfg_en  in  1  new channel enable.
- cfg_err  out  1  one-cycle pulse: rejected request.
- tick  out  NCH  per-channel one-cycle pulse, once per period.
- sq  out  NCH  per-channel square wave, period = div cycles.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State per channel: cnt[W], div[W], en, pend_valid, pend_div, pend_en. All outputs are registered.
- Reset (synchronous, any time, including mid-operation): cnt=0, div=RESET_DIV, en=EN_INIT, pend_valid=0, tick=0, sq=0, cfg_err=0, cfg_ready=1 on the next edge.
- Counting when en=1: cnt increments by 1. When cnt==div-1 (wrap edge), cnt<=0, tick<=1 and sq<=1; otherwise tick<=0.
- sq: sq<=1 while next cnt < hi, where hi=(div+1)>>1 (ceil half); otherwise 0. Odd div gives the extra cycle to high.
- First tick after reset release: on the div-th edge (cycles 0..div-1 count up). sq stays 0 until that first wrap.
- Disabled channel (en=0): cnt held at 0; tick=0 and sq=0 from the edge after disable.
- cfg_ready = !pend_valid[cfg_ch]. It is combinational from cfg_ch and must not depend on cfg_valid.
- Accepted request with cfg_div < 2: discarded, cfg_err<=1 for one cycle, no state change.
- Accepted valid request: pend_* written and pend_valid<=1.
- Applying pending to an enabled channel: applied on the channel's next wrap edge. div and en take pend values, pend_valid<=0.
  - If pend_en=0, cnt<=0, tick<=0 and sq<=0 on that same edge instead of starting a new period.
  - A wrap in the same cycle as acceptance uses the pre-existing pending state, so the new request applies at the following wrap.
- Applying pending to a disabled channel: applied on the edge after acceptance.
  - If pend_en=1, that edge starts a period immediately: cnt<=0, tick<=1, sq<=1.
- Independence: channels never interact. Simultaneous wraps on several channels are all honoured in the same cycle.
- Width rule: cnt and div are W bits with no overflow, since div-1 < 2^W. Comparisons are unsigned.

Optional Feature:
- Macro: MULTI_CLK_DIV_LOCK_GATE_EN.
- When defined:
  - Adds input port locked (1 bit), placed after rst, typically driven by a PLL lock output.
  - While locked=0, every channel behaves as disabled (cnt=0, tick=0, sq=0). Stored en/div/pending state and config acceptance are unaffected.
  - On the first cycle with locked=1, each enabled channel restarts exactly as after reset: first tick on the div-th edge.
- When undefined: no locked port, and channels run purely on en.

Decomposition:
- Package multi_clk_div_pkg holds:
  - MIN_DIV=2.
  - typedef chan_cfg_t {div, en}, parametrised via W.
  - Helper function half_up(div) = (div+1)>>1.
- Sub-module clk_div_chan: one channel (counter, pending slot, tick/sq regs, optional lock gate), instantiated NCH times in a generate loop.
- Top level handles: cfg_ch decode, cfg_ready mux, cfg_err register.

Test Plan:
All scenarios use NCH=3, W=8, RESET_DIV=10.
1. Reset release, no cfg → all channels tick on edges 10, 20, 30; sq high 5 cycles, low 5 cycles per period.
2. At ch1 cnt=3, write div=4, en=1 → ch1 ticks at 10, then 14, 18, 22; sq 2 high/2 low after edge 10; ch0 and ch2 unchanged.
3. Write ch0 div=5 → after the boundary, sq is 3 high/2 low and tick every 5 cycles.
4. Write ch2 div=1, then div=0 → cfg_err pulses once per request; ch2 period stays 10; pend_valid stays 0.
5. Disable ch2 at its cnt=6 → next wrap: tick/sq 0 and cnt held at 0. Re-enable 3 cycles later → tick the edge after acceptance, then every 10 cycles.
6. Two back-to-back writes to ch1 mid-period → cfg_ready low from the cycle after the first accept until ch1 wraps, then the second write is accepted. Also assert rst mid-period → all outputs 0 and counters 0 on the next edge.
7. With MULTI_CLK_DIV_LOCK_GATE_EN defined, hold locked=0 for 25 cycles after reset → no ticks; locked rises → first tick 10 edges later.
